// File: rtl/module_counter_gen.sv
// module_counter_gen: prescaled up/down event counter with wrap or saturate mode.
// A free-running prescaler divides clk by COUNT and every terminal prescaler
// cycle advances a WIDTH-bit counter by one. Outputs tick_o/term_o pulses for
// chaining.
// Optional build macro COUNT_OUT_INV_EN: drive count_o inverted (active-low LEDs).
module module_counter_gen #(
  parameter int COUNT = 13500000,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             sat_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             tick_o,
  output logic             term_o,
  output logic [WIDTH-1:0] count_o
);

  localparam int              PW       = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(COUNT - 1);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Result of one counter step: new value, terminal pulse, and whether to park
  typedef struct packed {
    logic             term;
    logic             hold;
    logic [WIDTH-1:0] val;
  } step_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_presc;
  logic [PW-1:0]    w_presc_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             r_tick;
  logic             r_term;
  logic             w_tick_nxt;
  logic             w_term_nxt;
  logic             w_hold_exit;
  step_t            w_step;

  // One counter step in the requested direction. In saturate mode the step
  // that lands on the limit (or a tick arriving while already at the limit)
  // flags term and asks to park; in wrap mode term flags the roll-over.
  function automatic step_t step_cnt(input logic [WIDTH-1:0] cnt,
                                     input logic up,
                                     input logic sat);
    step_t s;
    s.term = 1'b0;
    s.hold = 1'b0;
    s.val  = cnt;
    if (up) begin
      if (cnt == CNT_MAX) begin
        s.term = 1'b1;
        if (sat) s.hold = 1'b1;
        else     s.val  = CNT_MIN;
      end else begin
        s.val = cnt + 1'b1;
        if (sat && (s.val == CNT_MAX)) begin
          s.term = 1'b1;
          s.hold = 1'b1;
        end
      end
    end else begin
      if (cnt == CNT_MIN) begin
        s.term = 1'b1;
        if (sat) s.hold = 1'b1;
        else     s.val  = CNT_MAX;
      end else begin
        s.val = cnt - 1'b1;
        if (sat && (s.val == CNT_MIN)) begin
          s.term = 1'b1;
          s.hold = 1'b1;
        end
      end
    end
    return s;
  endfunction

  // Leave HOLD once the direction points away from the parked limit or
  // saturation is switched off (clear/load are handled with higher priority).
  assign w_hold_exit = ((r_cnt == CNT_MAX) && !dir_i) ||
                       ((r_cnt == CNT_MIN) &&  dir_i) ||
                       !sat_i;

  assign w_step = step_cnt(r_cnt, dir_i, sat_i);

  // Next-state and datapath decode: clear > load > enable gate > tick step
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_cnt_nxt   = r_cnt;
    w_tick_nxt  = 1'b0;
    w_term_nxt  = 1'b0;
    if (clr_i) begin
      w_cnt_nxt   = CNT_MIN;
      w_presc_nxt = '0;
      w_state_nxt = en_i ? RUN : IDLE;
    end else if (load_i) begin
      w_cnt_nxt   = load_val_i;
      w_presc_nxt = '0;
      w_state_nxt = en_i ? RUN : IDLE;
    end else if (!en_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        HOLD: begin
          if (w_hold_exit) w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = RUN;
          if (r_presc == PRE_LAST) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b1;
            w_cnt_nxt   = w_step.val;
            w_term_nxt  = w_step.term;
            if (w_step.hold) w_state_nxt = HOLD;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Prescaler, counter and registered output pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_term  <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tick  <= w_tick_nxt;
      r_term  <= w_term_nxt;
    end
  end

  assign tick_o = r_tick;
  assign term_o = r_term;
`ifdef COUNT_OUT_INV_EN
  assign count_o = ~r_cnt;
`else
  assign count_o = r_cnt;
`endif

endmodule

// File: tb/tb_module_counter_gen.sv
// Directed self-checking bench for module_counter_gen (COUNT=4, WIDTH=4).
module tb_module_counter_gen;

  logic       clk;
  logic       rst;
  logic       en_i;
  logic       dir_i;
  logic       sat_i;
  logic       clr_i;
  logic       load_i;
  logic [3:0] load_val_i;
  logic       tick_o;
  logic       term_o;
  logic [3:0] count_o;

  int n_chk;
  int n_fail;

  module_counter_gen #(.COUNT(4), .WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .dir_i      (dir_i),
    .sat_i      (sat_i),
    .clr_i      (clr_i),
    .load_i     (load_i),
    .load_val_i (load_val_i),
    .tick_o     (tick_o),
    .term_o     (term_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected count_o for a given counter value
  function automatic logic [3:0] ec(input logic [3:0] v);
`ifdef COUNT_OUT_INV_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int nt;
    int found;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    en_i = 1'b1;
    dir_i = 1'b1;
    sat_i = 1'b0;
    clr_i = 1'b0;
    load_i = 1'b0;
    load_val_i = 4'd0;

    // Reset state
    step(2);
    chk("rst_count", 32'(count_o), 32'(ec(4'd0)));
    chk("rst_tick", 32'(tick_o), 0);
    chk("rst_term", 32'(term_o), 0);

    // Count up with wrap: tick every 4 clk, term on 15 -> 0
    rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(3);
      chk("up_pre_tick", 32'(tick_o), 0);
      step(1);
      chk("up_tick", 32'(tick_o), 1);
      chk("up_count", 32'(count_o), 32'(ec(4'(i))));
      chk("up_term", 32'(term_o), 32'(i == 16));
    end

    // Count down from 0: wrap to 15 with term, then 14, 13
    dir_i = 1'b0;
    step(4);
    chk("dn_tick", 32'(tick_o), 1);
    chk("dn_count15", 32'(count_o), 32'(ec(4'd15)));
    chk("dn_term", 32'(term_o), 1);
    step(4);
    chk("dn_count14", 32'(count_o), 32'(ec(4'd14)));
    chk("dn_term14", 32'(term_o), 0);
    step(4);
    chk("dn_count13", 32'(count_o), 32'(ec(4'd13)));

    // Saturate up from a load of 14
    sat_i = 1'b1;
    dir_i = 1'b1;
    load_i = 1'b1;
    load_val_i = 4'd14;
    step(1);
    chk("sat_load", 32'(count_o), 32'(ec(4'd14)));
    chk("sat_load_tick", 32'(tick_o), 0);
    load_i = 1'b0;
    step(3);
    chk("sat_pre_tick", 32'(tick_o), 0);
    step(1);
    chk("sat_tick", 32'(tick_o), 1);
    chk("sat_count15", 32'(count_o), 32'(ec(4'd15)));
    chk("sat_term", 32'(term_o), 1);
    nt = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (tick_o) nt++;
      if (term_o) nt++;
    end
    chk("hold_no_pulse", 32'(nt), 0);
    chk("hold_count", 32'(count_o), 32'(ec(4'd15)));

    // Turn around out of HOLD: next tick gives 14
    dir_i = 1'b0;
    found = 0;
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (tick_o) begin
        found = 1;
        break;
      end
    end
    chk("hold_exit_tick", 32'(found), 1);
    chk("hold_exit_count", 32'(count_o), 32'(ec(4'd14)));
    chk("hold_exit_term", 32'(term_o), 0);

    // Freeze with en_i=0 at prescaler=2, then resume
    sat_i = 1'b0;
    step(2);
    en_i = 1'b0;
    nt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (tick_o) nt++;
    end
    chk("freeze_no_tick", 32'(nt), 0);
    chk("freeze_count", 32'(count_o), 32'(ec(4'd14)));
    en_i = 1'b1;
    step(1);
    chk("resume_pre_tick", 32'(tick_o), 0);
    step(1);
    chk("resume_tick", 32'(tick_o), 1);
    chk("resume_count", 32'(count_o), 32'(ec(4'd13)));

    // Clear+load coincident with a would-be wrapping tick
    load_i = 1'b1;
    load_val_i = 4'd0;
    step(1);
    chk("load0_count", 32'(count_o), 32'(ec(4'd0)));
    load_i = 1'b0;
    step(3);
    clr_i = 1'b1;
    load_i = 1'b1;
    load_val_i = 4'd9;
    step(1);
    chk("clr_count", 32'(count_o), 32'(ec(4'd0)));
    chk("clr_tick", 32'(tick_o), 0);
    chk("clr_term", 32'(term_o), 0);
    clr_i = 1'b0;
    step(1);
    chk("load9_count", 32'(count_o), 32'(ec(4'd9)));
    chk("load9_tick", 32'(tick_o), 0);
    load_i = 1'b0;
    step(3);
    chk("load9_pre_tick", 32'(tick_o), 0);
    step(1);
    chk("load9_tick4", 32'(tick_o), 1);
    chk("load9_count8", 32'(count_o), 32'(ec(4'd8)));

    // Asynchronous reset mid-count at 7
    step(4);
    chk("pre_rst_count7", 32'(count_o), 32'(ec(4'd7)));
    step(2);
    rst = 1'b0;
    #2;
    chk("async_rst_count", 32'(count_o), 32'(ec(4'd0)));
    chk("async_rst_tick", 32'(tick_o), 0);
    step(2);
    rst = 1'b1;
    step(3);
    chk("post_rst_pre_tick", 32'(tick_o), 0);
    step(1);
    chk("post_rst_tick", 32'(tick_o), 1);
    chk("post_rst_count", 32'(count_o), 32'(ec(4'd15)));
    chk("post_rst_term", 32'(term_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
